// File: rtl/axil_mm_pkg.sv
// Shared definitions for the AXI4-Lite to memory-mapped strobe bridge.
//   RESP_OKAY  : the only AXI response this bridge ever returns
//   w_state_e  : write-path FSM states
//   r_state_e  : read-path FSM states
package axil_mm_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_EXEC = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_EXEC = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

endpackage

// File: rtl/axil_mm_bridge.sv
// AXI4-Lite slave that turns register accesses into single-cycle strobes
// for a register file.
//   aclk/aresetn         : clock, async active-low reset
//   s_axi_aw*/w*/b*      : AXI4-Lite write channels (one write outstanding)
//   s_axi_ar*/r*         : AXI4-Lite read channels (one read outstanding)
//   wr_addr/wr_dout/wr_be/wr_en : registered MM write strobe
//   rd_addr/rd_en        : registered MM read strobe
//   rd_din               : MM read data, combinational from rd_addr
// Write and read paths are independent FSMs and may run concurrently.
module axil_mm_bridge
  import axil_mm_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_dout,
  output logic [DATA_W/8-1:0] wr_be,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_en,
  input  logic [DATA_W-1:0]   rd_din
);

  localparam int STRB_W = DATA_W / 8;

  // Keeps all readies low through reset and for the release edge itself.
  logic ready_en;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // ---------------------------------------------------------------- write
  w_state_e            w_state, w_next;
  logic                aw_held, w_held;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                aw_hs, w_hs, b_hs, w_go;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid  & s_axi_wready;
  assign b_hs  = s_axi_bvalid  & s_axi_bready;
  // Both halves present, counting a handshake landing on this edge.
  assign w_go  = (w_state == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        s_axi_awready = ready_en & ~aw_held;
        s_axi_wready  = ready_en & ~w_held;
        if (w_go) w_next = W_EXEC;
      end
      W_EXEC: w_next = W_RESP;
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign s_axi_bresp = RESP_OKAY;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_dout  <= '0;
      wr_be    <= '0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= s_axi_awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (b_hs) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      wr_en <= w_go;
      // Bypass the holding registers when the last handshake is this edge.
      if (w_go) begin
        wr_addr <= aw_hs ? s_axi_awaddr : awaddr_q;
        wr_dout <= w_hs  ? s_axi_wdata  : wdata_q;
        wr_be   <= w_hs  ? s_axi_wstrb  : wstrb_q;
      end
    end
  end

  // ----------------------------------------------------------------- read
  r_state_e r_state, r_next;
  logic     ar_hs;

  assign ar_hs = s_axi_arvalid & s_axi_arready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        s_axi_arready = ready_en;
        if (ar_hs) r_next = R_EXEC;
      end
      R_EXEC: r_next = R_RESP;
      R_RESP: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign s_axi_rresp = RESP_OKAY;

  // rd_addr doubles as the latched AR address. rdata is captured at the end
  // of the rd_en cycle, so a same-cycle write to the same word is not seen.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      s_axi_rdata <= '0;
    end else begin
      rd_en <= ar_hs;
      if (ar_hs)              rd_addr     <= s_axi_araddr;
      if (r_state == R_EXEC)  s_axi_rdata <= rd_din;
    end
  end

endmodule
